// File: rtl/bcd_timer_nd_pkg.sv
// Shared constants for the BCD timer: run-state encodings, segment code width, BCD limits.
package bcd_timer_nd_pkg;

    localparam logic [1:0] TMR_IDLE  = 2'd0;
    localparam logic [1:0] TMR_RUN   = 2'd1;
    localparam logic [1:0] TMR_PAUSE = 2'd2;
    localparam logic [1:0] TMR_DONE  = 2'd3;

    localparam int FTSD_CODE_W = 15;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_timer_nd_ftsd.sv
// FTSD segment decoder for one BCD digit; active-low codes, blank for non-BCD input.
module bcd_timer_nd_ftsd
    import bcd_timer_nd_pkg::*;
#(
    parameter int W = FTSD_CODE_W
) (
    input  logic [3:0]   digit,
    output logic [W-1:0] code
);

    logic [FTSD_CODE_W-1:0] raw;

    always_comb begin
        raw = 15'b111111111111111;
        case (digit)
            4'd0: raw = 15'b000000111111111;
            4'd1: raw = 15'b100111111111111;
            4'd2: raw = 15'b001001011111111;
            4'd3: raw = 15'b000011011111111;
            4'd4: raw = 15'b100110011111111;
            4'd5: raw = 15'b010010011111111;
            4'd6: raw = 15'b010000011111111;
            4'd7: raw = 15'b000111111111111;
            4'd8: raw = 15'b000000011111111;
            4'd9: raw = 15'b000010011111111;
            default: raw = 15'b111111111111111;
        endcase
    end

    assign code = W'(raw);

endmodule

// File: rtl/bcd_timer_nd.sv
// DIGITS-wide BCD up/down timer with IDLE/RUN/PAUSE/DONE run control, done pulse and FTSD outputs.
module bcd_timer_nd
    import bcd_timer_nd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int FTSD_W = FTSD_CODE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       load,
    input  logic [4*DIGITS-1:0]        load_val,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       up_dn,
    input  logic                       wrap,
    output logic [4*DIGITS-1:0]        bcd,
    output logic [FTSD_W*DIGITS-1:0]   ftsd,
    output logic                       running,
    output logic                       done
);

    logic [1:0]          state;
    logic [4*DIGITS-1:0] bcd_nxt;
    logic [DIGITS-1:0]   cy;
    logic [DIGITS-1:0]   term_dig;
    logic                nxt_term;
    logic                count_en;

    function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > BCD_NINE) r[4*i +: 4] = BCD_NINE;
        return r;
    endfunction

    // Ripple chain: cy[i] means digit i must step this tick (carry in up mode, borrow in down mode).
    assign cy[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] d;
        logic       at_lim;
        assign d      = bcd[4*i +: 4];
        assign at_lim = up_dn ? (d == BCD_NINE) : (d == BCD_ZERO);
        assign bcd_nxt[4*i +: 4] = !cy[i] ? d :
                                   at_lim ? (up_dn ? BCD_ZERO : BCD_NINE) :
                                   (up_dn ? d + 4'd1 : d - 4'd1);
        assign term_dig[i] = (bcd_nxt[4*i +: 4] == (up_dn ? BCD_NINE : BCD_ZERO));
        if (i < DIGITS - 1) begin : g_chain
            assign cy[i+1] = cy[i] & at_lim;
        end

        bcd_timer_nd_ftsd #(.W(FTSD_W)) u_ftsd (
            .digit (d),
            .code  (ftsd[FTSD_W*i +: FTSD_W])
        );
    end

    assign nxt_term = &term_dig;
    assign count_en = (state == TMR_RUN) && tick && !stop;
    assign running  = (state == TMR_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TMR_IDLE;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                bcd   <= clamp_bcd(load_val);
                state <= TMR_IDLE;
            end else begin
                if (stop) begin
                    if (state == TMR_RUN) state <= TMR_PAUSE;
                end else if (start && state != TMR_RUN) begin
                    state <= TMR_RUN;
                end
                // Reaching terminal pulses done; rollover out of terminal never does.
                if (count_en) begin
                    bcd <= bcd_nxt;
                    if (nxt_term) begin
                        done <= 1'b1;
                        if (!wrap) state <= TMR_DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_nd.sv
// Self-checking bench for bcd_timer_nd: integer-valued reference model, directed and random stimulus.
module tb_bcd_timer_nd;

    localparam int D   = 4;
    localparam int FW  = 15;
    localparam int MOD = 10000;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    localparam logic [14:0] CODES [10] = '{
        15'b000000111111111, 15'b100111111111111, 15'b001001011111111,
        15'b000011011111111, 15'b100110011111111, 15'b010010011111111,
        15'b010000011111111, 15'b000111111111111, 15'b000000011111111,
        15'b000010011111111};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic              up_dn = 1'b0, wrap = 1'b0;
    logic [4*D-1:0]    load_val = '0;
    logic [4*D-1:0]    bcd;
    logic [FW*D-1:0]   ftsd;
    logic              running, done;

    int tests = 0;
    int fails = 0;

    int m_val = 0;
    int m_st  = S_IDLE;
    bit m_done = 1'b0;

    bcd_timer_nd #(.DIGITS(D), .FTSD_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .up_dn(up_dn), .wrap(wrap),
        .bcd(bcd), .ftsd(ftsd), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int clamp_val(input logic [4*D-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < D; i++) begin
            int dg = int'(v[4*i +: 4]);
            if (dg > 9) dg = 9;
            r += dg * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x /= 10;
        end
        return r;
    endfunction

    function automatic logic [FW*D-1:0] exp_ftsd(input int v);
        logic [FW*D-1:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[FW*i +: FW] = CODES[x % 10];
            x /= 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_st = S_IDLE; m_done = 1'b0;
    endtask

    task automatic model_update();
        bit cnt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (load) begin
            m_val = clamp_val(load_val);
            m_st  = S_IDLE;
        end else begin
            cnt = (m_st == S_RUN) && tick && !stop;
            if (stop) begin
                if (m_st == S_RUN) m_st = S_PAUSE;
            end else if (start && m_st != S_RUN) begin
                m_st = S_RUN;
            end
            if (cnt) begin
                m_val = up_dn ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
                if (m_val == (up_dn ? MOD - 1 : 0)) begin
                    m_done = 1'b1;
                    if (!wrap) m_st = S_DONE;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_bcd"},     64'(bcd),     64'(to_bcd(m_val)));
        check({tag, "_done"},    64'(done),    64'(m_done));
        check({tag, "_running"}, 64'(running), 64'(m_st == S_RUN));
        check({tag, "_ftsd"},    64'(ftsd),    64'(exp_ftsd(m_val)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic idle_inputs();
        tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic do_load(input logic [4*D-1:0] v);
        idle_inputs(); load = 1'b1; load_val = v; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        idle_inputs(); start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_tick();
        idle_inputs(); tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    function automatic logic [3:0] rnd_digit();
        case ($urandom_range(0, 4))
            0: return 4'd0;
            1: return 4'd9;
            2: return 4'd1;
            3: return 4'd8;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        // Reset state
        #3;
        compare_all("reset");
        check("reset_ftsd_lit", 64'(ftsd), {4'h0, {4{15'b000000111111111}}});
        @(negedge clk);
        rst_n = 1'b1;

        // 1: down count 0012 to terminal, wrap=0
        up_dn = 1'b0; wrap = 1'b0;
        do_load(16'h0012);
        do_start();
        for (int k = 1; k <= 12; k++) begin
            do_tick();
            if (k == 11) check("t1_bcd11", 64'(bcd), 64'h0001);
            if (k == 11) check("t1_nodone11", 64'(done), 64'h0);
        end
        check("t1_done12", 64'(done), 64'h1);
        check("t1_bcd12", 64'(bcd), 64'h0000);
        repeat (3) do_tick();
        check("t1_hold", 64'(bcd), 64'h0000);
        check("t1_notrun", 64'(running), 64'h0);

        // 2: borrow across two digits, then clamped load
        do_load(16'h0100);
        do_start();
        do_tick();
        check("t2_borrow", 64'(bcd), 64'h0099);
        do_load(16'h0A3F);
        check("t2_clamp", 64'(bcd), 64'h0939);
        check("t2_idle", 64'(running), 64'h0);

        // 3: up with wrap through terminal
        up_dn = 1'b1; wrap = 1'b1;
        do_load(16'h9998);
        do_start();
        do_tick();
        check("t3_9999", 64'(bcd), 64'h9999);
        check("t3_done", 64'(done), 64'h1);
        do_tick();
        check("t3_0000", 64'(bcd), 64'h0000);
        check("t3_nodone", 64'(done), 64'h0);
        do_tick();
        check("t3_0001", 64'(bcd), 64'h0001);
        check("t3_running", 64'(running), 64'h1);

        // 4: stop beats tick, start+stop in PAUSE stays paused
        idle_inputs(); stop = 1'b1; tick = 1'b1; cyc(); idle_inputs();
        check("t4_paused_bcd", 64'(bcd), 64'h0001);
        check("t4_paused", 64'(running), 64'h0);
        idle_inputs(); stop = 1'b1; start = 1'b1; cyc(); idle_inputs();
        check("t4_still_paused", 64'(running), 64'h0);
        do_start();
        check("t4_resumed", 64'(running), 64'h1);
        do_tick();
        check("t4_0002", 64'(bcd), 64'h0002);

        // 5: load beats tick; direction follows up_dn per tick
        idle_inputs(); load = 1'b1; load_val = 16'h0500; tick = 1'b1; cyc(); idle_inputs();
        check("t5_load", 64'(bcd), 64'h0500);
        check("t5_idle", 64'(running), 64'h0);
        do_start();
        up_dn = 1'b1; do_tick();
        check("t5_up", 64'(bcd), 64'h0501);
        up_dn = 1'b0; do_tick(); do_tick();
        check("t5_down", 64'(bcd), 64'h0499);

        // 6: async reset mid-count
        do_load(16'h0060);
        do_start();
        repeat (3) do_tick();
        check("t6_0057", 64'(bcd), 64'h0057);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_bcd", 64'(bcd), 64'h0000);
        check("t6_rst_done", 64'(done), 64'h0);
        check("t6_rst_run", 64'(running), 64'h0);
        check("t6_rst_ftsd", 64'(ftsd), {4'h0, {4{15'b000000111111111}}});
        @(negedge clk);
        compare_all("t6_held");
        rst_n = 1'b1;

        // Random phase
        for (int n = 0; n < 800; n++) begin
            idle_inputs();
            load  = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            tick  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 19) == 0) wrap = ~wrap;
            for (int i = 0; i < D; i++) load_val[4*i +: 4] = rnd_digit();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
